sc_spi_stc_burst: RTL and testbench



---
 rtl/sc_spi_stc_burst_pkg.sv | 20 ++
 rtl/sc_spi_stc_burst_if.sv | 37 +++
 rtl/sc_spi_stc_burst_dncnt.sv | 27 ++
 rtl/sc_spi_stc_burst.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_sc_spi_stc_burst.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_spi_stc_burst_pkg.sv
// Shared definitions for the SPI burst transfer controller: FSM state encoding
// and default parameter values.
package sc_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EXEC  = 3'd2,
        ST_TRANS = 3'd3,
        ST_GAP   = 3'd4,
        ST_END   = 3'd5
    } stc_state_t;

    localparam int CSSEL_W_DEF     = 5;
    localparam int DW_W_DEF        = 9;
    localparam int BURST_W_DEF     = 8;
    localparam int GAP_W_DEF       = 8;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/sc_spi_stc_burst_if.sv
// Controller-to-SCG/SPC bus: clock-generator control, latched transfer
// configuration and the SPC start/busy handshake.
interface sc_spi_stc_burst_if
    import sc_spi_pkg::*;
#(
    parameter int CSSEL_W = CSSEL_W_DEF,
    parameter int DW_W    = DW_W_DEF
);
    logic               CLK_ENABLE;
    logic [7:0]         CLK_WIDTH_HIGH;
    logic [7:0]         CLK_WIDTH_LOW;
    logic [3:0]         SPC_CSSETUP;
    logic [3:0]         SPC_CSHOLD;
    logic [DW_W-1:0]    SPC_DWIDTH;
    logic               SPC_CPOL;
    logic               SPC_CPHA;
    logic               SPC_BORDER;
    logic [CSSEL_W-1:0] SPC_CSSEL;
    logic               SPC_CSEXTEND;
    logic               SPC_SPISTART;
    logic               SPC_SPIBUSY;

    modport master (
        output CLK_ENABLE, CLK_WIDTH_HIGH, CLK_WIDTH_LOW,
        output SPC_CSSETUP, SPC_CSHOLD, SPC_DWIDTH, SPC_CPOL, SPC_CPHA,
        output SPC_BORDER, SPC_CSSEL, SPC_CSEXTEND, SPC_SPISTART,
        input  SPC_SPIBUSY
    );

    modport slave (
        input  CLK_ENABLE, CLK_WIDTH_HIGH, CLK_WIDTH_LOW,
        input  SPC_CSSETUP, SPC_CSHOLD, SPC_DWIDTH, SPC_CPOL, SPC_CPHA,
        input  SPC_BORDER, SPC_CSSEL, SPC_CSEXTEND, SPC_SPISTART,
        output SPC_SPIBUSY
    );

endinterface

// File: rtl/sc_spi_stc_burst_dncnt.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module sc_spi_stc_dncnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstb,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rstb) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sc_spi_stc_burst.sv
// SPI burst transfer controller: one TXSTART runs BURSTLEN+1 SPC transfers with CS
// held across the burst. Optional SPC start timeout: SC_SPI_STC_BURST_TIMEOUT_EN.
module sc_spi_stc_burst
    import sc_spi_pkg::*;
#(
    parameter int CSSEL_W     = CSSEL_W_DEF,
    parameter int DW_W        = DW_W_DEF,
    parameter int BURST_W     = BURST_W_DEF,
    parameter int GAP_W       = GAP_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               SYSCLK,
    input  logic               SYSRSTB,
    input  logic [7:0]         CLKHIGH,
    input  logic [7:0]         CLKLOW,
    input  logic [3:0]         CSSETUP,
    input  logic [3:0]         CSHOLD,
    input  logic [DW_W-1:0]    DWIDTH,
    input  logic               CPOL,
    input  logic               CPHA,
    input  logic               BORDER,
    input  logic               CSEXTEND,
    input  logic [CSSEL_W-1:0] CSSEL,
    input  logic [BURST_W-1:0] BURSTLEN,
    input  logic [GAP_W-1:0]   GAPCYC,
    input  logic               TXSTART,
    input  logic               ABORT,
    output logic               SPIBUSY,
    output logic               SPICOMPLETE,
    output logic               XFERDONE,
    output logic [BURST_W-1:0] XFERIDX,
    output logic               ABORTED,
    output logic               ERROR,
    sc_spi_stc_burst_if.master spc
);

    stc_state_t         r_state;
    stc_state_t         w_state_nxt;

    logic [BURST_W-1:0] r_remaining;
    logic [GAP_W-1:0]   r_gapcyc;
    logic               r_csextend;
    logic               r_abort_pend;

    logic               r_spibusy;
    logic               r_spicomplete;
    logic               r_xferdone;
    logic [BURST_W-1:0] r_xferidx;
    logic               r_aborted;
    logic               r_clk_enable;
    logic [7:0]         r_clk_high;
    logic [7:0]         r_clk_low;
    logic [3:0]         r_cssetup;
    logic [3:0]         r_cshold;
    logic [DW_W-1:0]    r_dwidth;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_border;
    logic [CSSEL_W-1:0] r_cssel;
    logic               r_spc_csextend;
    logic               r_spistart;

    logic               w_abort;
    logic               w_last;
    logic               w_accept;
    logic               w_launch;
    logic               w_xfer_end;
    logic               w_to_gap;
    logic               w_to_end;
    logic               w_to_idle;
    logic               w_gap_zero;
    logic               w_tmo;

    // A pending abort or an abort arriving this cycle both count as "stop after this transfer"
    assign w_abort = r_abort_pend | ABORT;
    assign w_last  = (r_remaining == '0);

    sc_spi_stc_dncnt #(
        .W (GAP_W)
    ) u_gap_cnt (
        .i_clk  (SYSCLK),
        .i_rstb (SYSRSTB),
        .i_load (w_to_gap),
        .i_val  (r_gapcyc),
        .i_dec  (r_state == ST_GAP),
        .o_zero (w_gap_zero)
    );

`ifdef SC_SPI_STC_BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic w_tmo_zero;
    logic r_error;

    // Loaded on EXEC entry so the count covers exactly TIMEOUT_CYC EXEC cycles
    sc_spi_stc_dncnt #(
        .W (TMO_W)
    ) u_tmo_cnt (
        .i_clk  (SYSCLK),
        .i_rstb (SYSRSTB),
        .i_load (w_launch),
        .i_val  (TMO_LOAD),
        .i_dec  (r_state == ST_EXEC),
        .o_zero (w_tmo_zero)
    );

    assign w_tmo = (r_state == ST_EXEC) && !spc.SPC_SPIBUSY && w_tmo_zero;

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_tmo) begin
            r_error <= 1'b1;
        end
    end

    assign ERROR = r_error;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign w_tmo        = 1'b0;
    assign ERROR        = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (TXSTART) w_state_nxt = ST_SETUP;
            ST_SETUP: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (spc.SPC_SPIBUSY) begin
                    w_state_nxt = ST_TRANS;
                end else if (w_tmo) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_TRANS: begin
                if (!spc.SPC_SPIBUSY) begin
                    w_state_nxt = (w_last || w_abort) ? ST_END : ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_abort) begin
                    w_state_nxt = ST_END;
                end else if (w_gap_zero) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_END:   if (!spc.SPC_SPIBUSY) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = 1'b0;
        w_launch   = 1'b0;
        w_xfer_end = 1'b0;
        w_to_gap   = 1'b0;
        w_to_end   = 1'b0;
        w_to_idle  = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept = TXSTART;
            ST_SETUP: w_launch = 1'b1;
            ST_TRANS: begin
                w_xfer_end = !spc.SPC_SPIBUSY;
                w_to_gap   = (w_state_nxt == ST_GAP);
            end
            ST_END:   w_to_idle = (w_state_nxt == ST_IDLE);
            default:  ;
        endcase
        if ((r_state != ST_END) && (w_state_nxt == ST_END)) begin
            w_to_end = 1'b1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            r_remaining    <= '0;
            r_gapcyc       <= '0;
            r_csextend     <= 1'b0;
            r_abort_pend   <= 1'b0;
            r_spibusy      <= 1'b0;
            r_spicomplete  <= 1'b0;
            r_xferdone     <= 1'b0;
            r_xferidx      <= '0;
            r_aborted      <= 1'b0;
            r_clk_enable   <= 1'b0;
            r_clk_high     <= '0;
            r_clk_low      <= '0;
            r_cssetup      <= '0;
            r_cshold       <= '0;
            r_dwidth       <= '0;
            r_cpol         <= 1'b0;
            r_cpha         <= 1'b0;
            r_border       <= 1'b0;
            r_cssel        <= '0;
            r_spc_csextend <= 1'b0;
            r_spistart     <= 1'b0;
        end else begin
            r_spicomplete <= w_to_end;
            r_xferdone    <= w_xfer_end;

            if (w_accept) begin
                r_remaining <= BURSTLEN;
                r_gapcyc    <= GAPCYC;
                r_csextend  <= CSEXTEND;
                r_clk_high  <= CLKHIGH;
                r_clk_low   <= CLKLOW;
                r_cssetup   <= CSSETUP;
                r_cshold    <= CSHOLD;
                r_dwidth    <= DWIDTH;
                r_cpol      <= CPOL;
                r_cpha      <= CPHA;
                r_border    <= BORDER;
                r_cssel     <= CSSEL;
                r_xferidx   <= '0;
                r_aborted   <= 1'b0;
                r_spibusy   <= 1'b1;
            end

            // CS stays asserted between transfers; the programmed extend applies only to the last one
            if (w_launch) begin
                r_spistart     <= 1'b1;
                r_clk_enable   <= 1'b1;
                r_spc_csextend <= (!w_last && !w_abort) ? 1'b1 : r_csextend;
            end else if ((r_spistart && spc.SPC_SPIBUSY) || w_tmo) begin
                r_spistart <= 1'b0;
            end

            if (w_to_gap) begin
                r_remaining <= r_remaining - 1'b1;
                r_xferidx   <= r_xferidx + 1'b1;
            end

            if (w_to_end) begin
                r_spc_csextend <= r_csextend;
                if (w_abort) begin
                    r_aborted <= 1'b1;
                end
            end

            if (w_to_idle) begin
                r_spibusy    <= 1'b0;
                r_clk_enable <= 1'b0;
            end

            if (w_state_nxt == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if ((r_state != ST_IDLE) && ABORT) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign SPIBUSY            = r_spibusy;
    assign SPICOMPLETE        = r_spicomplete;
    assign XFERDONE           = r_xferdone;
    assign XFERIDX            = r_xferidx;
    assign ABORTED            = r_aborted;

    assign spc.CLK_ENABLE     = r_clk_enable;
    assign spc.CLK_WIDTH_HIGH = r_clk_high;
    assign spc.CLK_WIDTH_LOW  = r_clk_low;
    assign spc.SPC_CSSETUP    = r_cssetup;
    assign spc.SPC_CSHOLD     = r_cshold;
    assign spc.SPC_DWIDTH     = r_dwidth;
    assign spc.SPC_CPOL       = r_cpol;
    assign spc.SPC_CPHA       = r_cpha;
    assign spc.SPC_BORDER     = r_border;
    assign spc.SPC_CSSEL      = r_cssel;
    assign spc.SPC_CSEXTEND   = r_spc_csextend;
    assign spc.SPC_SPISTART   = r_spistart;

endmodule

// File: tb/tb_sc_spi_stc_burst.sv
// Bench for sc_spi_stc_burst: SPC behavioural model plus a start scoreboard
// holding the expected index / CS-extend / launch latency of every transfer.
module tb_sc_spi_stc_burst;
    import sc_spi_pkg::*;

    localparam int CSSEL_W = 5;
    localparam int DW_W    = 9;
    localparam int BURST_W = 8;
    localparam int GAP_W   = 8;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    logic [7:0]         clkhigh, clklow;
    logic [3:0]         cssetup, cshold;
    logic [DW_W-1:0]    dwidth;
    logic               cpol, cpha, border, csextend;
    logic [CSSEL_W-1:0] cssel;
    logic [BURST_W-1:0] burstlen;
    logic [GAP_W-1:0]   gapcyc;
    logic               txstart, abort;
    logic               spibusy, spicomplete, xferdone, aborted, error;
    logic [BURST_W-1:0] xferidx;

    sc_spi_stc_burst_if #(.CSSEL_W(CSSEL_W), .DW_W(DW_W)) spc_if();

    sc_spi_stc_burst #(
        .CSSEL_W(CSSEL_W), .DW_W(DW_W), .BURST_W(BURST_W), .GAP_W(GAP_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .SYSCLK(clk), .SYSRSTB(rstb),
        .CLKHIGH(clkhigh), .CLKLOW(clklow), .CSSETUP(cssetup), .CSHOLD(cshold),
        .DWIDTH(dwidth), .CPOL(cpol), .CPHA(cpha), .BORDER(border), .CSEXTEND(csextend),
        .CSSEL(cssel), .BURSTLEN(burstlen), .GAPCYC(gapcyc), .TXSTART(txstart), .ABORT(abort),
        .SPIBUSY(spibusy), .SPICOMPLETE(spicomplete), .XFERDONE(xferdone), .XFERIDX(xferidx),
        .ABORTED(aborted), .ERROR(error), .spc(spc_if)
    );

    typedef struct {
        int   idx;
        logic csx;
        logic first;
        int   gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   tx_cyc = 0;
    int   fall_cyc = 0;
    int   start_cyc = 0;
    int   n_done = 0;
    int   n_cmpl = 0;
    int   busy_len = 10;
    int   bcnt = 0;
    logic never_busy = 1'b0;
    logic prev_start = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_cfg();
        return 64'({spc_if.CLK_WIDTH_HIGH, spc_if.CLK_WIDTH_LOW, spc_if.SPC_CSSETUP,
                    spc_if.SPC_CSHOLD, spc_if.SPC_DWIDTH, spc_if.SPC_CPOL, spc_if.SPC_CPHA,
                    spc_if.SPC_BORDER, spc_if.SPC_CSSEL});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer and SPC model; the model drives busy away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (spc_if.SPC_SPISTART && !prev_start) begin
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("xferidx_at_start", 64'(xferidx), 64'(e.idx));
                check("csextend_at_start", 64'(spc_if.SPC_CSEXTEND), 64'(e.csx));
                if (e.first) check("start_latency", 64'(cyc - tx_cyc), 64'd2);
                else         check("gap_latency", 64'(cyc - fall_cyc), 64'(e.gap + 2));
            end
        end
        prev_start = spc_if.SPC_SPISTART;
        if (xferdone)    n_done++;
        if (spicomplete) n_cmpl++;
        if (!rstb) begin
            spc_if.SPC_SPIBUSY = 1'b0;
            bcnt = 0;
        end else if (spc_if.SPC_SPIBUSY) begin
            bcnt--;
            if (bcnt == 0) begin
                spc_if.SPC_SPIBUSY = 1'b0;
                fall_cyc = cyc + 1;
            end
        end else if (spc_if.SPC_SPISTART && !never_busy) begin
            spc_if.SPC_SPIBUSY = 1'b1;
            bcnt = busy_len;
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_spibusy"}, 64'(spibusy), 64'd0);
        check({tag, "_pulses"}, 64'({spicomplete, xferdone}), 64'd0);
        check({tag, "_xferidx"}, 64'(xferidx), 64'd0);
        check({tag, "_status"}, 64'({aborted, error}), 64'd0);
        check({tag, "_spc_ctrl"}, 64'({spc_if.CLK_ENABLE, spc_if.SPC_SPISTART, spc_if.SPC_CSEXTEND}), 64'd0);
        check({tag, "_spc_cfg"}, dut_cfg(), 64'd0);
    endtask

    task automatic start_burst(input int blen, input int gap, input logic csx, input int blat,
                               input int nexp);
        logic [63:0] cfg_exp;
        for (int i = 0; i < nexp; i++)
            exp_q.push_back('{idx: i, csx: (i < blen) ? 1'b1 : csx, first: (i == 0), gap: gap});
        busy_len = blat;
        n_done   = 0;
        n_cmpl   = 0;
        clkhigh  = 8'(8'h20 + blen);
        clklow   = 8'(8'h40 + gap);
        cssetup  = 4'(blen + 1);
        cshold   = 4'(gap);
        dwidth   = 9'(100 + blen);
        cpol     = 1'b1;
        cpha     = csx;
        border   = ~csx;
        cssel    = 5'(blen + 3);
        burstlen = 8'(blen);
        gapcyc   = 8'(gap);
        csextend = csx;
        cfg_exp  = 64'({clkhigh, clklow, cssetup, cshold, dwidth, cpol, cpha, border, cssel});
        txstart  = 1'b1;
        tx_cyc   = cyc;
        @(negedge clk);
        txstart = 1'b0;
        check("spibusy_set", 64'(spibusy), 64'd1);
        // Scramble inputs and retrigger while busy: neither may affect the running burst
        clkhigh  = ~clkhigh;
        clklow   = ~clklow;
        dwidth   = ~dwidth;
        cssel    = ~cssel;
        burstlen = 8'd0;
        gapcyc   = 8'hff;
        csextend = ~csx;
        repeat (2) @(negedge clk);
        txstart = 1'b1;
        @(negedge clk);
        txstart = 1'b0;
        check("cfg_latched", dut_cfg(), cfg_exp);
    endtask

    task automatic wait_idx(input int idx, input logic need_busy);
        int t = 0;
        while (!((int'(xferidx) == idx) && (spc_if.SPC_SPIBUSY || !need_busy)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("wait_xferidx_timeout", 64'(xferidx), 64'(idx));
    endtask

    // mode 0: full burst, 1: abort during transfer 1, 2: abort in the gap after transfer 0
    task automatic run_burst(input int blen, input int gap, input logic csx, input int blat,
                             input int mode);
        int nexp;
        int t;
        nexp = (mode == 1) ? 2 : (mode == 2) ? 1 : blen + 1;
        start_burst(blen, gap, csx, blat, nexp);
        if (mode != 0) begin
            wait_idx(1, mode == 1);
            if (mode == 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        t = 0;
        while (!spicomplete && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("complete_timeout", 64'd0, 64'd1);
        check("spibusy_at_complete", 64'(spibusy), 64'd1);
        @(negedge clk);
        check("complete_one_cycle", 64'(spicomplete), 64'd0);
        check("spibusy_fall", 64'(spibusy), 64'd0);
        check("clk_enable_off", 64'(spc_if.CLK_ENABLE), 64'd0);
        check("xferdone_count", 64'(n_done), 64'(nexp));
        check("complete_count", 64'(n_cmpl), 64'd1);
        check("starts_outstanding", 64'(exp_q.size()), 64'd0);
        check("aborted", 64'(aborted), 64'(mode != 0));
        check("error", 64'(error), 64'd0);
        check("final_csextend", 64'(spc_if.SPC_CSEXTEND), 64'(csx));
        check("final_xferidx", 64'(xferidx), 64'((mode == 2) ? 1 : nexp - 1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; txstart = 1'b0; abort = 1'b0;
        clkhigh = '0; clklow = '0; cssetup = '0; cshold = '0; dwidth = '0;
        cpol = 1'b0; cpha = 1'b0; border = 1'b0; csextend = 1'b0; cssel = '0;
        burstlen = '0; gapcyc = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rstb = 1'b1;
        @(negedge clk);

        run_burst(0, 3, 1'b1, 10, 0);
        run_burst(3, 4, 1'b0, 10, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        run_burst(1, 0, 1'b1, 6, 0);
        run_burst(3, 4, 1'b0, 10, 1);
        run_burst(3, 20, 1'b0, 10, 2);

        // SPC that never acknowledges the start
        never_busy = 1'b1;
        start_burst(0, 0, 1'b1, 10, 1);
`ifdef SC_SPI_STC_BURST_TIMEOUT_EN
        begin
            int t = 0;
            while (!spicomplete && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("tmo_complete_timeout", 64'd0, 64'd1);
            check("tmo_latency", 64'(cyc - start_cyc), 64'(TMO));
            check("tmo_error", 64'(error), 64'd1);
            check("tmo_spistart_low", 64'(spc_if.SPC_SPISTART), 64'd0);
            @(negedge clk);
            check("tmo_spibusy_fall", 64'(spibusy), 64'd0);
        end
`else
        repeat (40) @(negedge clk);
        check("hang_spibusy", 64'(spibusy), 64'd1);
        check("hang_no_complete", 64'(n_cmpl), 64'd0);
        check("hang_spistart_held", 64'(spc_if.SPC_SPISTART), 64'd1);
        check("hang_error", 64'(error), 64'd0);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
`endif
        never_busy = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the gap ahead of transfer 2, then a clean burst
        start_burst(3, 8, 1'b0, 10, 2);
        wait_idx(2, 1'b0);
        rstb = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_mid_burst");
        check("reset_starts_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rstb = 1'b1;
        @(negedge clk);
        run_burst(2, 1, 1'b1, 5, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no summary, want completion within bound");
        $fatal(1);
    end

endmodule
